// File: rtl/bsg_comm_link_pkg.sv
// Shared comm-link types and sizing helpers.
// Used by both ends of the link so credit widths agree.
package bsg_comm_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int credits_max(input int lg_depth);
    return 1 << lg_depth;
  endfunction

endpackage

// File: rtl/bsg_comm_link_credit_counter.sv
// Saturating credit counter: +2**lg_step_p per token, -1 per send.
// Reinit forces the count back to max_p.
module bsg_comm_link_credit_counter
  import bsg_comm_link_pkg::*;
#(
  parameter int width_p   = 6,
  parameter int max_p     = 32,
  parameter int lg_step_p = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               reinit_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [width_p-1:0] count_o,
  output logic               sat_o
);

  localparam logic [width_p:0] STEP =
    (width_p+1)'(1 << lg_step_p);
  localparam logic [width_p:0] MAXW =
    (width_p+1)'(max_p);
  localparam logic [width_p-1:0] MAXV =
    width_p'(max_p);

  logic [width_p-1:0] count_q, count_d;
  logic [width_p:0]   sum;
  logic               sat;

  // One extra bit so an over-max sum is visible.
  always_comb begin
    sum = {1'b0, count_q};
    sum = sum - {{width_p{1'b0}}, dec_i};
    if (inc_i) sum = sum + STEP;
    sat = (sum > MAXW);
    count_d = sum[width_p-1:0];
    if (sat) count_d = MAXV;
    if (reinit_i) count_d = MAXV;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= MAXV;
    else          count_q <= count_d;
  end

  assign count_o = count_q;
  assign sat_o   = sat & ~reinit_i;

endmodule

// File: rtl/bsg_comm_link_credit_tx.sv
// Credit-based per-channel transmit stage of the comm link.
// BSG_COMM_LINK_CREDIT_TX_ERR_EN enables the sticky overflow flag.
module bsg_comm_link_credit_tx
  import bsg_comm_link_pkg::*;
#(
  parameter int channel_width_p                 = 8,
  parameter int lg_input_fifo_depth_p           = 5,
  parameter int lg_credit_to_token_decimation_p = 3
) (
  input  logic                         clk_i,
  input  logic                         async_reset_n_i,
  input  logic                         calib_done_i,
  input  logic                         core_v_i,
  input  logic [channel_width_p-1:0]   core_data_i,
  output logic                         core_ready_o,
  output logic                         io_v_o,
  output logic [channel_width_p-1:0]   io_data_o,
  input  logic                         io_ready_i,
  input  logic                         token_toggle_i,
  output logic [lg_input_fifo_depth_p:0] credits_o,
  output logic                         err_o
);

  localparam int CW = lg_input_fifo_depth_p + 1;
  localparam int CMAX = credits_max(lg_input_fifo_depth_p);

  state_e state_q, state_d;
  logic   token_q;
  logic   io_v_q;
  logic [channel_width_p-1:0] io_data_q;
  logic [CW-1:0] credits;
  logic   tok, accept, reinit, sat, run;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (calib_done_i)  state_d = RUN;
      RUN:  if (!calib_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  assign run    = (state_q == RUN);
  assign reinit = (state_d == IDLE);
  assign tok    = run & (token_toggle_i ^ token_q);

  assign core_ready_o = run & (credits != '0)
                      & (~io_v_q | io_ready_i);
  assign accept = core_v_i & core_ready_o;

  // Tracking the line in every state means IDLE exit sees no false token.
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) token_q <= 1'b0;
    else                  token_q <= token_toggle_i;
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      io_v_q    <= 1'b0;
      io_data_q <= '0;
    end else if (reinit) begin
      io_v_q    <= 1'b0;
      io_data_q <= '0;
    end else if (accept) begin
      io_v_q    <= 1'b1;
      io_data_q <= core_data_i;
    end else if (io_ready_i) begin
      io_v_q    <= 1'b0;
    end
  end

  bsg_comm_link_credit_counter #(
    .width_p  (CW),
    .max_p    (CMAX),
    .lg_step_p(lg_credit_to_token_decimation_p)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (async_reset_n_i),
    .reinit_i(reinit),
    .inc_i   (tok),
    .dec_i   (accept),
    .count_o (credits),
    .sat_o   (sat)
  );

`ifdef BSG_COMM_LINK_CREDIT_TX_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) err_q <= 1'b0;
    else if (reinit)      err_q <= 1'b0;
    else if (sat)         err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign err_o = 1'b0;
`endif

  assign io_v_o    = io_v_q;
  assign io_data_o = io_data_q;
  assign credits_o = credits;

endmodule
